// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional trailer checksum is enabled by defining IMEM_BOOT_CHECKSUM_EN.
package imem_boot_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);
  localparam int COUNT_W    = 8 * HDR_BYTES;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    LOAD,
    WRITE,
    TRAILER,
    HOLD,
    RUN,
    ERROR
  } state_e;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts(state_e s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == LOAD) || (s == TRAILER);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core control of the boot loader.
// slave = loader side, master = stream source / memory / core side.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  done;
  logic                  err;

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs bytes little-endian into a 32-bit word; word_full_o flags the push that
// completes a word, and word_o already includes that incoming byte.
module byte_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic        word_full_o,
  output logic [31:0] word_o
);

  logic [LANE_W-1:0]              lane_q;
  logic [WORD_BYTES-1:0][7:0]     lanes_q;
  logic [WORD_BYTES-1:0][7:0]     word_v;

  always_comb begin
    word_v         = lanes_q;
    word_v[lane_q] = data_i;
  end

  assign word_o      = word_v;
  assign word_full_o = push_i && (lane_q == LANE_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= '0;
    end else if (push_i) begin
      lane_q <= lane_q + 1'b1;
    end
  end

  // Lane data needs no reset: every lane is rewritten before a word completes.
  always_ff @(posedge clk) begin
    if (push_i) begin
      lanes_q[lane_q] <= data_i;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: header (word count), payload packed into imem words, then core release.
// Define IMEM_BOOT_CHECKSUM_EN to require an XOR trailer byte after the payload.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int RELEASE_DELAY = 3
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus
);

  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_e LAST_NEXT = TRAILER;
`else
  localparam state_e LAST_NEXT = HOLD;
`endif

  state_e                state_q, state_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [3:0]            delay_q, delay_d;
  logic                  s_ready_q, s_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic               fire;
  logic               word_full;
  logic [31:0]        word;
  logic [COUNT_W-1:0] hdr_cnt;

  assign fire    = bus.s_valid && s_ready_q;
  assign hdr_cnt = {bus.s_data, count_q[7:0]};

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fire && (state_q == LOAD)),
    .data_i     (bus.s_data),
    .word_full_o(word_full),
    .word_o     (word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= HDR_LO;
      count_q      <= '0;
      idx_q        <= '0;
      delay_q      <= '0;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      delay_q      <= delay_d;
      s_ready_q    <= s_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    delay_d = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      HDR_LO: if (fire) begin
        count_d[7:0] = bus.s_data;
        state_d      = HDR_HI;
      end
      HDR_HI: if (fire) begin
        count_d = hdr_cnt;
        if (hdr_cnt == '0)                state_d = LAST_NEXT;
        else if (32'(hdr_cnt) > CAP)      state_d = ERROR;
        else                              state_d = LOAD;
      end
      LOAD: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (fire) csum_d = csum_q ^ bus.s_data;
`endif
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = ((32'(idx_q) + 32'd1) == 32'(count_q)) ? LAST_NEXT : LOAD;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      TRAILER: if (fire) begin
        state_d = (bus.s_data == csum_q) ? HOLD : ERROR;
      end
`endif
      // HOLD lasts RELEASE_DELAY+1 cycles so release lands RELEASE_DELAY+1 edges after entry.
      HOLD: begin
        if (delay_q == 4'(RELEASE_DELAY)) state_d = RUN;
        else                              delay_d = delay_q + 1'b1;
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_comb begin
    s_ready_d    = accepts(state_d);
    imem_we_d    = (state_d == WRITE);
    imem_addr_d  = (state_d == WRITE) ? idx_q[ADDR_WIDTH-1:0] : imem_addr_q;
    imem_wdata_d = word_full ? word : imem_wdata_q;
    core_rst_d   = (state_d == RUN);
    done_d       = (state_d == RUN);
    err_d        = (state_d == ERROR);
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
